utopia_rx_fifo: RTL and testbench
=================================

UTOPIA_RX_FIFO -- requirements
Module: utopia_rx_fifo

Interface
REQ-001 SHALL have parameter CELL_BYTES, default 53, giving the ATM cell length in bytes.
REQ-002 SHALL have parameter DEPTH_CELLS, default 2, giving the number of complete-cell slots (power of 2, at least 2).
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data  input  8  UTOPIA Rx cell byte.
REQ-006 SHALL have port rx_soc  input  1  start-of-cell; marks byte 0.
REQ-007 SHALL have port rx_en_n  input  1  active-low byte enable; byte is offered when 0.
REQ-008 SHALL have port rx_clav  output  1  cell available; 1 = room for one more full cell.
REQ-009 SHALL have port out_data  output  8  byte toward switch core Rx port.
REQ-010 SHALL have port out_soc  output  1  marks byte 0 of the outgoing cell.
REQ-011 SHALL have port out_valid  output  1  out_data/out_soc valid.
REQ-012 SHALL have port out_ready  input  1  core accepts the byte.
REQ-013 SHALL have port cell_count  output  $clog2(DEPTH_CELLS)+1  committed cells held.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of dropped cells/bytes.

Function
REQ-015 SHALL sample rx_* on rising clk; a byte is accepted when rx_en_n=0 and a write slot is open.
REQ-016 SHALL run a write FSM with states IDLE and FILL, plus a byte index wr_idx 0..CELL_BYTES-1.
REQ-017 IDLE: an accepted byte with rx_soc=1 SHALL be stored at index 0, setting wr_idx=1 and moving to FILL.
REQ-018 IDLE: an offered byte with rx_soc=0 SHALL be discarded, with drop_cnt incremented.
REQ-019 FILL: an accepted byte with rx_soc=0 SHALL be stored at wr_idx and wr_idx incremented.
REQ-020 FILL: an accepted byte at wr_idx=CELL_BYTES-1 SHALL commit the cell: wr slot pointer advances modulo DEPTH_CELLS, cell_count increments, and the FSM returns to IDLE.
REQ-021 FILL: rx_soc=1 at wr_idx!=0 SHALL abandon the partial cell (no commit) and increment drop_cnt; that byte SHALL be stored as byte 0 of the same slot, with wr_idx=1 and the FSM remaining in FILL.
REQ-022 rx_clav SHALL be registered and equal to (cell_count + (FSM==FILL ? 1 : 0) < DEPTH_CELLS) || (FSM==FILL), i.e. 1 while the current slot is open or a free slot exists.
REQ-023 A byte offered in IDLE with no free slot (cell_count==DEPTH_CELLS) SHALL be discarded, with drop_cnt incremented once per cell start (rx_soc=1) only.
REQ-024 Read side: out_valid SHALL be 1 whenever cell_count>0.
REQ-025 out_data SHALL equal the stored byte at read slot/rd_idx; out_soc SHALL be 1 when rd_idx==0 and out_valid=1.
REQ-026 A transfer occurs on out_valid & out_ready; rd_idx increments on each transfer.
REQ-027 On a transfer at rd_idx=CELL_BYTES-1, rd_idx SHALL be 0, the read slot SHALL advance modulo DEPTH_CELLS, and cell_count SHALL decrement.
REQ-028 out_valid SHALL not drop mid-cell; the core may stall (out_ready=0) indefinitely with outputs held stable.
REQ-029 Latency: a commit at edge N SHALL give out_valid=1 after edge N (first cell, empty FIFO).
REQ-030 Simultaneous commit and read-release in the same cycle SHALL leave cell_count unchanged.
REQ-031 drop_cnt SHALL saturate at 255.

Reset
REQ-032 On rst=0 (async): FSM=IDLE, wr_idx=rd_idx=0, both slot pointers 0, cell_count=0, drop_cnt=0, rx_clav=0, out_valid=0, out_soc=0, out_data=0.
REQ-033 rx_clav SHALL become 1 on the first clk edge after rst deasserts; a partial cell in progress at reset is lost and not counted.

Verification
REQ-034 Single cell bytes 0x00..0x34, soc on first, out_ready=1 -> 53 output bytes 0x00..0x34, out_soc only on first, cell_count 1->0, drop_cnt=0.
REQ-035 Default config, out_ready=0, three cells sent -> rx_clav=0 after second commit, third cell dropped, cell_count=2, drop_cnt=1.
REQ-036 soc reasserted at byte 20, then a full 53-byte cell -> only the second cell is output, drop_cnt=1.
REQ-037 Stray byte without soc in IDLE -> discarded, drop_cnt=1, no out_valid.
REQ-038 Last byte of cell B committed on the same edge cell A's last byte is read -> cell_count stays 1, B is output next with out_soc=1.
REQ-039 rst pulled low mid-cell (byte 30) with out_valid=1 -> all outputs 0 immediately; after release a fresh cell passes intact.

Source files
------------

// File: rtl/utopia_rx_fifo.sv
// UTOPIA receive-side cell FIFO: gathers bytes into whole-cell slots and only
// forwards complete cells to the switch core, dropping malformed or overflowing cells.
module utopia_rx_fifo #(
    parameter int CELL_BYTES  = 53,
    parameter int DEPTH_CELLS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_soc,
    input  logic                         rx_en_n,
    output logic                         rx_clav,
    output logic [7:0]                   out_data,
    output logic                         out_soc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH_CELLS):0] cell_count,
    output logic [7:0]                   drop_cnt,
    output logic                         wr_state_dbg
);

    localparam int IW = (CELL_BYTES > 1) ? $clog2(CELL_BYTES) : 1;
    localparam int SW = $clog2(DEPTH_CELLS);
    localparam int CW = SW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CELL_BYTES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH_CELLS);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } wr_state_t;

    wr_state_t       state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [SW-1:0]   wr_slot_q, wr_slot_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [SW-1:0]   rd_slot_q, rd_slot_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q;
    logic            clav_q, clav_d;

    logic            mem_we;
    logic [IW-1:0]   mem_idx;
    logic            commit;
    logic            drop_inc;
    logic            rd_fire;
    logic            cell_done;

    logic [7:0]      mem [DEPTH_CELLS][CELL_BYTES];

    // Write side. In FILL the slot is already owned, so any offered byte is taken;
    // a new SOC there restarts the same slot rather than claiming another one.
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        wr_slot_d = wr_slot_q;
        mem_we    = 1'b0;
        mem_idx   = wr_idx_q;
        commit    = 1'b0;
        drop_inc  = 1'b0;
        if (!rx_en_n) begin
            case (state_q)
                IDLE: begin
                    if (rx_soc) begin
                        if (count_q < DEPTH_C) begin
                            mem_we   = 1'b1;
                            mem_idx  = '0;
                            wr_idx_d = IW'(1);
                            state_d  = FILL;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end else if (count_q < DEPTH_C) begin
                        // When full, only the SOC of a refused cell is counted.
                        drop_inc = 1'b1;
                    end
                end
                FILL: begin
                    mem_we = 1'b1;
                    if (rx_soc) begin
                        drop_inc = 1'b1;
                        mem_idx  = '0;
                        wr_idx_d = IW'(1);
                    end else if (wr_idx_q == LAST_IDX) begin
                        commit    = 1'b1;
                        wr_idx_d  = '0;
                        wr_slot_d = wr_slot_q + SW'(1);
                        state_d   = IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // out_valid/out_ready: a byte moves on every rising edge where both are high;
    // out_valid never falls inside a cell and out_data/out_soc hold while out_ready is low.
    assign out_valid = (count_q != '0);
    assign rd_fire   = out_valid && out_ready;
    assign cell_done = rd_fire && (rd_idx_q == LAST_IDX);
    assign out_soc   = out_valid && (rd_idx_q == '0);
    assign out_data  = out_valid ? mem[rd_slot_q][rd_idx_q] : 8'h00;

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_slot_d = rd_slot_q;
        if (rd_fire) begin
            if (cell_done) begin
                rd_idx_d  = '0;
                rd_slot_d = rd_slot_q + SW'(1);
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({commit, cell_done})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Registered from next-state values so rx_clav always describes the current state.
    assign clav_d = (state_d == FILL) || (count_d < DEPTH_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_idx_q  <= '0;
            wr_slot_q <= '0;
            rd_idx_q  <= '0;
            rd_slot_q <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            clav_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            wr_slot_q <= wr_slot_d;
            rd_idx_q  <= rd_idx_d;
            rd_slot_q <= rd_slot_d;
            count_q   <= count_d;
            clav_q    <= clav_d;
            if (drop_inc && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Cell storage carries no reset; unread contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_slot_q][mem_idx] <= rx_data;
        end
    end

    assign rx_clav      = clav_q;
    assign cell_count   = count_q;
    assign drop_cnt     = drop_q;
    assign wr_state_dbg = (state_q == FILL);

endmodule

// File: tb/tb_utopia_rx_fifo.sv
// Directed bench for utopia_rx_fifo: drivers push expected {soc,data} into a queue,
// a negedge monitor pops and compares on every transfer.
module tb_utopia_rx_fifo;

    localparam int CB = 53;
    localparam int DC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_soc = 1'b0;
    logic       rx_en_n = 1'b1;
    logic       rx_clav;
    logic [7:0] out_data;
    logic       out_soc;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [$clog2(DC):0] cell_count;
    logic [7:0] drop_cnt;
    logic       wr_state_dbg;

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    utopia_rx_fifo #(.CELL_BYTES(CB), .DEPTH_CELLS(DC)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_soc(rx_soc),
        .rx_en_n(rx_en_n),
        .rx_clav(rx_clav),
        .out_data(out_data),
        .out_soc(out_soc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cell_count(cell_count),
        .drop_cnt(drop_cnt),
        .wr_state_dbg(wr_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // monitor / scoreboard
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 32'({out_valid, out_soc, out_data}), 32'({1'b1, prev_out}));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", {out_soc, out_data});
                end else begin
                    check("out_byte", 32'({out_soc, out_data}), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_soc, out_data};
        end
    end

    // drivers
    task automatic drive(input logic [7:0] d, input logic s);
        rx_data = d;
        rx_soc  = s;
        rx_en_n = 1'b0;
        @(posedge clk);
        #1;
        rx_en_n = 1'b1;
        rx_soc  = 1'b0;
    endtask

    task automatic send_cell(input logic [7:0] base, input int n, input logic expect_out);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i);
            if (expect_out) exp_q.push_back({(i == 0), d});
            drive(d, (i == 0));
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k < 3000), 32'(1));
        check({name, "_q_empty"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_soc", 32'(out_soc), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_rx_clav", 32'(rx_clav), 32'(0));
        check("rst_cell_count", 32'(cell_count), 32'(0));
        check("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("clav_before_edge", 32'(rx_clav), 32'(0));
        @(posedge clk);
        #1;
        check("clav_after_edge", 32'(rx_clav), 32'(1));

        // single cell 0x00..0x34 straight through
        out_ready = 1'b1;
        send_cell(8'h00, CB, 1'b1);
        check("t1_count_commit", 32'(cell_count), 32'(1));
        check("t1_valid_commit", 32'(out_valid), 32'(1));
        wait_drain("t1_drain");
        check("t1_count_end", 32'(cell_count), 32'(0));
        check("t1_drop", 32'(drop_cnt), 32'(0));

        // stray byte without soc in IDLE
        drive(8'hAA, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_drop", 32'(drop_cnt), 32'(1));
        check("t2_valid", 32'(out_valid), 32'(0));
        check("t2_count", 32'(cell_count), 32'(0));

        // soc reasserted at byte 20, then a full cell
        send_cell(8'h40, 20, 1'b0);
        check("t3_fill_state", 32'(wr_state_dbg), 32'(1));
        send_cell(8'h80, CB, 1'b1);
        wait_drain("t3_drain");
        check("t3_drop", 32'(drop_cnt), 32'(2));

        // overflow with core stalled
        out_ready = 1'b0;
        send_cell(8'h10, CB, 1'b1);
        check("t4_clav_one", 32'(rx_clav), 32'(1));
        send_cell(8'h20, CB, 1'b1);
        check("t4_clav_full", 32'(rx_clav), 32'(0));
        check("t4_count_full", 32'(cell_count), 32'(2));
        send_cell(8'h30, CB, 1'b0);
        check("t4_drop", 32'(drop_cnt), 32'(3));
        check("t4_count", 32'(cell_count), 32'(2));
        check("t4_head", 32'({out_valid, out_soc, out_data}), 32'({2'b11, 8'h10}));
        out_ready = 1'b1;
        wait_drain("t4_drain");

        // commit of B on the same edge as release of A
        out_ready = 1'b0;
        send_cell(8'h50, CB, 1'b1);
        out_ready = 1'b1;
        send_cell(8'h60, CB, 1'b1);
        check("t5_count", 32'(cell_count), 32'(1));
        check("t5_head", 32'({out_valid, out_soc, out_data}), 32'({2'b11, 8'h60}));
        wait_drain("t5_drain");

        // reset mid-cell while a cell is presented
        out_ready = 1'b0;
        send_cell(8'h70, CB, 1'b1);
        send_cell(8'hA0, 30, 1'b0);
        check("t6_pre_valid", 32'(out_valid), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'(0));
        check("t6_out_soc", 32'(out_soc), 32'(0));
        check("t6_out_data", 32'(out_data), 32'(0));
        check("t6_rx_clav", 32'(rx_clav), 32'(0));
        check("t6_count", 32'(cell_count), 32'(0));
        check("t6_drop", 32'(drop_cnt), 32'(0));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_clav_release", 32'(rx_clav), 32'(1));
        out_ready = 1'b1;
        send_cell(8'h90, CB, 1'b1);
        wait_drain("t6_drain");
        check("t6_drop_end", 32'(drop_cnt), 32'(0));
        check("t6_count_end", 32'(cell_count), 32'(0));

        // drop counter saturation
        for (int i = 0; i < 260; i++) drive(8'(i), 1'b0);
        check("t7_drop_sat", 32'(drop_cnt), 32'(255));
        check("t7_valid", 32'(out_valid), 32'(0));

        repeat (3) @(posedge clk);
        check("final_q_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
